// File: rtl/tile_prog_sequencer.sv
// Tile program sequencer: walks a tile from run mode through dead-time, settle,
// gate and drain pulses, recovery and back, with abort and row-range checking.
module tile_prog_sequencer #(
    parameter int unsigned SETTLE   = 8,
    parameter int unsigned NUM_ROWS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_drain,
    input  logic [1:0]  cmd_gate,
    input  logic [15:0] cmd_len,
    input  logic        cmd_last,
    input  logic        abort,
    output logic [4:0]  drain_b,
    output logic [1:0]  gate_b,
    output logic        drain_en,
    output logic        gate_en,
    output logic        prog,
    output logic        run,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        R_IDLE, DEAD_IN, SETUP, GATE_ON, PULSE, RECOVER, P_IDLE, DEAD_OUT
    } state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE - 1);
    localparam logic [5:0]  ROW_LIMIT   = 6'(NUM_ROWS);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [4:0]  drain_q, drain_nxt;
    logic [1:0]  gate_q, gate_nxt;
    logic [15:0] len_q, len_nxt;
    logic        last_q, last_nxt;
    logic        aborted, aborted_nxt;
    logic        accept;
    logic        run_nxt, prog_nxt, ready_nxt, gate_en_nxt, drain_en_nxt;
    logic        addr_on, done_nxt, err_nxt;

    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        drain_nxt   = drain_q;
        gate_nxt    = gate_q;
        len_nxt     = len_q;
        last_nxt    = last_q;
        aborted_nxt = aborted;
        err_nxt     = 1'b0;

        case (state)
            R_IDLE, P_IDLE: begin
                if (accept) begin
                    if ({1'b0, cmd_drain} < ROW_LIMIT) begin
                        drain_nxt   = cmd_drain;
                        gate_nxt    = cmd_gate;
                        len_nxt     = cmd_len;
                        last_nxt    = cmd_last;
                        aborted_nxt = 1'b0;
                        if (state == R_IDLE) begin
                            state_nxt = DEAD_IN;
                        end else begin
                            state_nxt = SETUP;
                            cnt_nxt   = SETTLE_LOAD;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            DEAD_IN: begin
                state_nxt = SETUP;
                cnt_nxt   = SETTLE_LOAD;
            end
            SETUP, GATE_ON, PULSE: begin
                if (abort) begin
                    state_nxt   = RECOVER;
                    cnt_nxt     = SETTLE_LOAD;
                    aborted_nxt = 1'b1;
                    err_nxt     = 1'b1;
                end else if (cnt != 16'd0) begin
                    cnt_nxt = cnt - 16'd1;
                end else begin
                    case (state)
                        SETUP: begin
                            state_nxt = GATE_ON;
                            cnt_nxt   = SETTLE_LOAD;
                        end
                        GATE_ON: begin
                            // zero length is stretched to a single pulse cycle
                            state_nxt = PULSE;
                            cnt_nxt   = (len_q == 16'd0) ? 16'd0 : len_q - 16'd1;
                        end
                        default: begin
                            state_nxt = RECOVER;
                            cnt_nxt   = SETTLE_LOAD;
                        end
                    endcase
                end
            end
            RECOVER: begin
                if (cnt != 16'd0) begin
                    cnt_nxt = cnt - 16'd1;
                end else begin
                    state_nxt = (last_q || aborted) ? DEAD_OUT : P_IDLE;
                end
            end
            DEAD_OUT: begin
                state_nxt   = R_IDLE;
                aborted_nxt = 1'b0;
            end
            default: begin
                state_nxt = R_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // outputs are decoded from the next state so they register alongside it
        run_nxt      = (state_nxt == R_IDLE);
        prog_nxt     = state_nxt inside {SETUP, GATE_ON, PULSE, RECOVER, P_IDLE};
        ready_nxt    = (state_nxt == R_IDLE) || (state_nxt == P_IDLE);
        gate_en_nxt  = (state_nxt == GATE_ON) || (state_nxt == PULSE);
        drain_en_nxt = (state_nxt == PULSE);
        addr_on      = state_nxt inside {SETUP, GATE_ON, PULSE, RECOVER};
        done_nxt     = (state_nxt == RECOVER) && (cnt_nxt == 16'd0) && !aborted_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= R_IDLE;
            cnt       <= '0;
            drain_q   <= '0;
            gate_q    <= '0;
            len_q     <= '0;
            last_q    <= 1'b0;
            aborted   <= 1'b0;
            run       <= 1'b1;
            prog      <= 1'b0;
            cmd_ready <= 1'b1;
            gate_en   <= 1'b0;
            drain_en  <= 1'b0;
            drain_b   <= '0;
            gate_b    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            drain_q   <= drain_nxt;
            gate_q    <= gate_nxt;
            len_q     <= len_nxt;
            last_q    <= last_nxt;
            aborted   <= aborted_nxt;
            run       <= run_nxt;
            prog      <= prog_nxt;
            cmd_ready <= ready_nxt;
            gate_en   <= gate_en_nxt;
            drain_en  <= drain_en_nxt;
            drain_b   <= addr_on ? drain_nxt : '0;
            gate_b    <= addr_on ? gate_nxt : '0;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_tile_prog_sequencer.sv
// Directed bench for tile_prog_sequencer: a table of single commands plus
// hand-written back-to-back, abort, reset and long-pulse sequences.
module tb_tile_prog_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_drain;
    logic [1:0]  cmd_gate;
    logic [15:0] cmd_len;
    logic        cmd_last;
    logic        abort;
    logic [4:0]  drain_b;
    logic [1:0]  gate_b;
    logic        drain_en;
    logic        gate_en;
    logic        prog;
    logic        run;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    tile_prog_sequencer #(.SETTLE(8), .NUM_ROWS(20)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_drain(cmd_drain), .cmd_gate(cmd_gate), .cmd_len(cmd_len),
        .cmd_last(cmd_last), .abort(abort), .drain_b(drain_b), .gate_b(gate_b),
        .drain_en(drain_en), .gate_en(gate_en), .prog(prog), .run(run),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  drain;
        logic [1:0]  gate;
        logic [15:0] len;
        logic        last;
        int          dead, prog_n, gate_n, drain_n, done_n, err_n, done_at;
    } vec_t;

    typedef struct {
        int dead, prog_n, gate_n, drain_n, done_n, err_n, done_at, addr_bad, timeout;
    } meas_t;

    vec_t vecs[7];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Present one command at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [4:0] d, input logic [1:0] g, input logic [15:0] l,
                         input logic lst, input logic ab);
        check("ready_before_issue", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_drain = d; cmd_gate = g; cmd_len = l; cmd_last = lst; abort = ab;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
    endtask

    // Count output activity cycle by cycle until the sequencer is idle (R_IDLE or P_IDLE).
    task automatic measure(input logic [4:0] d, input logic [1:0] g, input int budget,
                           output meas_t m);
        int cyc;
        m = '{default: 0};
        cyc = 0;
        forever begin
            if (!prog && !run) m.dead++;
            if (prog) m.prog_n++;
            if (gate_en) m.gate_n++;
            if (drain_en) begin
                m.drain_n++;
                if (drain_b != d || gate_b != g) m.addr_bad++;
            end
            if (done) begin
                m.done_n++;
                m.done_at = m.prog_n;
            end
            if (err) m.err_n++;
            if ((run && !prog) || (prog && cmd_ready)) break;
            cyc++;
            if (cyc >= budget) begin
                m.timeout = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_meas(input string tag, input meas_t m, input int dead, input int pn,
                              input int gn, input int dn, input int don, input int en,
                              input int dat);
        check({tag, "_timeout"}, m.timeout, 0);
        check({tag, "_dead"}, m.dead, dead);
        check({tag, "_prog"}, m.prog_n, pn);
        check({tag, "_gate_en"}, m.gate_n, gn);
        check({tag, "_drain_en"}, m.drain_n, dn);
        check({tag, "_done"}, m.done_n, don);
        check({tag, "_err"}, m.err_n, en);
        check({tag, "_done_at"}, m.done_at, dat);
        check({tag, "_addr"}, m.addr_bad, 0);
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while (!drain_en && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_drain_start"}, int'(drain_en), 1);
    endtask

    // Continuous safety monitor on prog/run exclusivity, dead-cycle and enable nesting.
    logic mon_en = 1'b0;
    logic rst_window = 1'b0;
    logic prev_run, prev_prog;
    int   dead_run;
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (prog && run) begin
                n_fail++;
                $display("FAIL mon_prog_run: prog=%0b run=%0b expected not both 1", prog, run);
            end
            if (drain_en && !(gate_en && prog)) begin
                n_fail++;
                $display("FAIL mon_drain_en: drain_en=1 gate_en=%0b prog=%0b expected both 1", gate_en, prog);
            end
            if (!rst_window && ((prev_run && prog) || (prev_prog && run))) begin
                n_fail++;
                $display("FAIL mon_dead: run/prog switched with no dead cycle");
            end
            dead_run = (!prog && !run) ? dead_run + 1 : 0;
            if (dead_run > 1) begin
                n_fail++;
                $display("FAIL mon_dead_len: got %0d dead cycles expected 1", dead_run);
            end
        end else begin
            dead_run = 0;
        end
        prev_run  = run;
        prev_prog = prog;
    end

    initial begin
        meas_t m;

        vecs[0] = '{5'd3,  2'd2, 16'd20, 1'b1, 2, 44, 28, 20, 1, 0, 44};
        vecs[1] = '{5'd0,  2'd0, 16'd0,  1'b1, 2, 25,  9,  1, 1, 0, 25};
        vecs[2] = '{5'd19, 2'd3, 16'd1,  1'b1, 2, 25,  9,  1, 1, 0, 25};
        vecs[3] = '{5'd7,  2'd1, 16'd3,  1'b1, 2, 27, 11,  3, 1, 0, 27};
        vecs[4] = '{5'd25, 2'd1, 16'd5,  1'b1, 0,  0,  0,  0, 0, 1,  0};
        vecs[5] = '{5'd20, 2'd0, 16'd5,  1'b0, 0,  0,  0,  0, 0, 1,  0};
        vecs[6] = '{5'd31, 2'd3, 16'd9,  1'b1, 0,  0,  0,  0, 0, 1,  0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_drain = '0; cmd_gate = '0;
        cmd_len = '0; cmd_last = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_run", int'(run), 1);
        check("rst_prog", int'(prog), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_enables", int'({drain_en, gate_en}), 0);
        check("rst_addr", int'({drain_b, gate_b}), 0);
        check("rst_done_err", int'({done, err}), 0);
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].drain, vecs[i].gate, vecs[i].len, vecs[i].last, 1'b0);
            measure(vecs[i].drain, vecs[i].gate, 200, m);
            check_meas($sformatf("vec%0d", i), m, vecs[i].dead, vecs[i].prog_n, vecs[i].gate_n,
                       vecs[i].drain_n, vecs[i].done_n, vecs[i].err_n, vecs[i].done_at);
            check($sformatf("vec%0d_end_ready", i), int'(cmd_ready), 1);
            @(negedge clk);
            check($sformatf("vec%0d_err_pulse", i), int'(err), 0);
        end

        // back-to-back: first command parks in P_IDLE, second goes straight to SETUP
        issue(5'd5, 2'd1, 16'd4, 1'b0, 1'b0);
        measure(5'd5, 2'd1, 200, m);
        check_meas("b2b_first", m, 1, 29, 12, 4, 1, 0, 28);
        check("b2b_pidle_prog", int'({prog, run, cmd_ready}), 3'b101);
        check("b2b_pidle_addr", int'({drain_b, gate_b}), 0);
        issue(5'd9, 2'd2, 16'd2, 1'b1, 1'b0);
        check("b2b_setup_prog", int'({prog, run}), 2'b10);
        check("b2b_setup_drain_b", int'(drain_b), 9);
        check("b2b_setup_gate_b", int'(gate_b), 2);
        measure(5'd9, 2'd2, 200, m);
        check_meas("b2b_second", m, 1, 26, 10, 2, 1, 0, 26);

        // abort on the fifth pulse cycle, even with last=0 the tile returns to run
        @(negedge clk);
        issue(5'd4, 2'd0, 16'd100, 1'b0, 1'b0);
        wait_drain("abort");
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_enables", int'({drain_en, gate_en}), 0);
        check("abort_err", int'(err), 1);
        measure(5'd4, 2'd0, 200, m);
        check_meas("abort_recover", m, 1, 8, 0, 0, 0, 1, 0);
        check("abort_run", int'(run), 1);

        // abort coinciding with an accept in R_IDLE is ignored
        @(negedge clk);
        issue(5'd2, 2'd1, 16'd2, 1'b1, 1'b1);
        check("abort_idle_dead", int'({prog, run, err}), 0);
        measure(5'd2, 2'd1, 200, m);
        check_meas("abort_idle", m, 2, 26, 10, 2, 1, 0, 26);

        // reset mid-pulse drops straight to run mode
        @(negedge clk);
        issue(5'd6, 2'd3, 16'd50, 1'b1, 1'b0);
        wait_drain("rst");
        repeat (3) @(negedge clk);
        rst_window = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_pulse_run_prog", int'({run, prog}), 2'b10);
        check("rst_pulse_enables", int'({drain_en, gate_en}), 0);
        check("rst_pulse_addr", int'({drain_b, gate_b}), 0);
        check("rst_pulse_ready", int'(cmd_ready), 1);
        check("rst_pulse_done_err", int'({done, err}), 0);
        @(negedge clk);
        rst_window = 1'b0;

        // longest pulse is honoured without wrapping
        @(negedge clk);
        issue(5'd1, 2'd1, 16'd65535, 1'b1, 1'b0);
        measure(5'd1, 2'd1, 70000, m);
        check_meas("len_max", m, 2, 65559, 65543, 65535, 1, 0, 65559);

        @(negedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
